adder_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one combinational n-bit adder between NREQ requesters.
- Selects one request per cycle, steers that requester's operands onto the shared adder, and registers the sum with the requester ID.
- The result is presented on a valid/ready output port.
- Sits between the datapath units that need an add (PC+4, branch target, address generation) and a single shared adder instance.

---
 rtl/adder_arbiter.sv | 94 +++++++++
 tb/tb_adder_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one external n-bit adder between NREQ
// requesters and registers each sum, tagged with its owner, on a valid/ready port.
module adder_arbiter #(
  parameter int n    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*n-1:0] a_in,
  input  logic [NREQ*n-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [n-1:0]      add_a,
  output logic [n-1:0]      add_b,
  input  logic [n-1:0]      add_y,
  output logic [n-1:0]      y,
  output logic [IDW-1:0]    y_id,
  output logic              y_valid,
  input  logic              y_ready
);

  localparam int PW = IDW + 1;

  logic [n-1:0]   y_q, y_d;
  logic [IDW-1:0] y_id_q, y_id_d;
  logic           y_valid_q, y_valid_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           can_accept;
  logic           grant;
  logic [IDW-1:0] win;
  logic [PW-1:0]  idx;

  // Scan starts at ptr and wraps; one extra bit keeps ptr+k from overflowing.
  always_comb begin
    can_accept = !y_valid_q || y_ready;
    grant      = 1'b0;
    win        = '0;
    idx        = '0;
    gnt        = '0;
    add_a      = '0;
    add_b      = '0;
    if (can_accept && !reset) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = {1'b0, ptr_q} + PW'(k);
        if (idx >= PW'(NREQ)) idx = idx - PW'(NREQ);
        if (!grant && req[idx[IDW-1:0]]) begin
          grant = 1'b1;
          win   = idx[IDW-1:0];
        end
      end
    end
    if (grant) begin
      gnt[win] = 1'b1;
      add_a    = a_in[win*n +: n];
      add_b    = b_in[win*n +: n];
    end
  end

  always_comb begin
    y_d       = y_q;
    y_id_d    = y_id_q;
    y_valid_d = y_valid_q;
    ptr_d     = ptr_q;
    if (grant) begin
      y_d       = add_y;
      y_id_d    = win;
      y_valid_d = 1'b1;
      ptr_d     = (32'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end else if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q       <= '0;
      y_id_q    <= '0;
      y_valid_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      y_q       <= y_d;
      y_id_q    <= y_id_d;
      y_valid_q <= y_valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign y       = y_q;
  assign y_id    = y_id_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed vector table, hand-written corner sequences,
// and random traffic checked against a request-level round-robin model.
module tb_adder_arbiter;
  localparam int N  = 32;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req, gnt;
  logic [NR*N-1:0] a_in, b_in;
  logic [N-1:0]    add_a, add_b, add_y, y;
  logic [1:0]      y_id;
  logic            y_valid, y_ready;

  int n_tests = 0;
  int n_fail  = 0;

  adder_arbiter #(.n(N), .NREQ(NR)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_y(add_y),
    .y(y), .y_id(y_id), .y_valid(y_valid), .y_ready(y_ready)
  );

  // The shared adder lives outside the arbiter.
  assign add_y = add_a + add_b;

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   req;
    logic [127:0] a, b;
    logic         rdy;
    logic [3:0]   gnt;
    logic [31:0]  y;
    logic [1:0]   id;
    logic         v;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [127:0] pk(input logic [31:0] v3, v2, v1, v0);
    return {v3, v2, v1, v0};
  endfunction

  function automatic vec_t mk(input logic [3:0] r, input logic [127:0] a, b,
                              input logic rdy, input logic [3:0] g,
                              input logic [31:0] yy, input logic [1:0] id, input logic v);
    vec_t t;
    t.req = r; t.a = a; t.b = b; t.rdy = rdy; t.gnt = g; t.y = yy; t.id = id; t.v = v;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered at posedge+1: drive, check combinational outputs, clock, check registers.
  task automatic cycle(input logic [3:0] r, input logic [127:0] a, b, input logic rdy,
                       input logic [3:0] eg, input logic [31:0] eaa, eab, ey,
                       input logic [1:0] eid, input logic ev);
    req = r; a_in = a; b_in = b; y_ready = rdy;
    #2;
    check("gnt", gnt, eg);
    check("add_a", add_a, eaa);
    check("add_b", add_b, eab);
    @(posedge clk); #1;
    check("y_valid", y_valid, ev);
    check("y", y, ey);
    check("y_id", y_id, eid);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; a_in = '0; b_in = '0; y_ready = 1'b0;
    @(posedge clk); #1;
    req = 4'b1111;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_add_a", add_a, 0);
    check("rst_y", y, 0);
    check("rst_y_id", y_id, 0);
    check("rst_y_valid", y_valid, 0);
    req = '0;
    reset = 1'b0;
  endtask

  logic [31:0] pa[NR], pb[NR];
  bit          pend[NR];
  logic [31:0] m_y;
  logic [1:0]  m_id;
  logic        m_valid;
  int          m_ptr;

  initial begin
    logic [3:0]   r, eg;
    logic [127:0] av, bv;
    logic [31:0]  eaa, eab;
    logic         rdy, g;
    int           w;

    do_reset();

    // All requesters held from reset: strict 0,1,2,3 rotation, one result per cycle.
    for (int i = 0; i < 8; i++) begin
      w = i % 4;
      cycle(4'b1111, pk(3, 2, 1, 0), pk(30, 20, 10, 0), 1'b1, 4'(1 << w),
            32'(w), 32'(w * 10), 32'(11 * w), 2'(w), 1'b1);
    end

    do_reset();
    tbl[0] = mk(4'b0100, pk(0, 5, 0, 0), pk(0, 7, 0, 0), 1'b1, 4'b0100, 12, 2, 1'b1);
    tbl[1] = mk(4'b0001, pk(0, 0, 0, 32'hFFFF_FFFF), pk(0, 0, 0, 2), 1'b1, 4'b0001, 1, 0, 1'b1);
    for (int i = 2; i < 5; i++)
      tbl[i] = mk(4'b0010, pk(0, 0, 10, 0), pk(0, 0, 20, 0), 1'b0, 4'b0000, 1, 0, 1'b1);
    tbl[5] = mk(4'b0010, pk(0, 0, 10, 0), pk(0, 0, 20, 0), 1'b1, 4'b0010, 30, 1, 1'b1);
    tbl[6] = mk(4'b0000, '0, '0, 1'b1, 4'b0000, 30, 1, 1'b0);
    tbl[7] = mk(4'b0000, '0, '0, 1'b0, 4'b0000, 30, 1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      w = (2 + i) % 4;
      tbl[8 + i] = mk(4'b1111, pk(3, 2, 1, 0), pk(30, 20, 10, 0), 1'b1, 4'(1 << w),
                      32'(11 * w), 2'(w), 1'b1);
    end
    for (int i = 0; i < 16; i++) begin
      eaa = '0; eab = '0;
      for (int j = 0; j < 4; j++)
        if (tbl[i].gnt[j]) begin
          eaa = tbl[i].a[j*32 +: 32];
          eab = tbl[i].b[j*32 +: 32];
        end
      cycle(tbl[i].req, tbl[i].a, tbl[i].b, tbl[i].rdy, tbl[i].gnt, eaa, eab,
            tbl[i].y, tbl[i].id, tbl[i].v);
    end

    // Result pending with ptr=2: reset drops it immediately, then requester 0 wins.
    reset = 1'b1;
    #1;
    check("midrst_y_valid", y_valid, 0);
    check("midrst_y", y, 0);
    check("midrst_gnt", gnt, 0);
    check("midrst_add_a", add_a, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(4'b1111, pk(1, 1, 1, 7), pk(1, 1, 1, 8), 1'b1, 4'b0001, 7, 8, 15, 0, 1'b1);

    do_reset();
    m_y = '0; m_id = '0; m_valid = 1'b0; m_ptr = 0;
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
          pb[i] = $urandom;
        end
        r[i] = pend[i];
        av[i*32 +: 32] = pend[i] ? pa[i] : $urandom;
        bv[i*32 +: 32] = pend[i] ? pb[i] : $urandom;
      end
      rdy = ($urandom_range(0, 3) != 0);
      g = 1'b0; w = 0;
      if (!m_valid || rdy)
        for (int k = 0; k < NR; k++)
          if (!g && r[(m_ptr + k) % NR]) begin
            g = 1'b1;
            w = (m_ptr + k) % NR;
          end
      eg = '0; eaa = '0; eab = '0;
      if (g) begin
        eg = 4'(1 << w); eaa = pa[w]; eab = pb[w];
        m_y = pa[w] + pb[w];
        m_id = 2'(w);
        m_valid = 1'b1;
        m_ptr = (w + 1) % NR;
        pend[w] = 1'b0;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      cycle(r, av, bv, rdy, eg, eaa, eab, m_y, m_id, m_valid);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
